sdram_scheduler: RTL and testbench
==================================

SDRAM_SCHEDULER -- requirements
Module: sdram_scheduler

Interface
REQ-001 Parameter FREQ, default 54_000_000, clk frequency in Hz.
REQ-002 Parameter REFRESH_US, default 15, refresh interval in microseconds; REFRESH_CYCLES = FREQ/1_000_000*REFRESH_US (810 at defaults).
REQ-003 clk  input  1  system clock, same clock as the SDRAM controller's clk.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  port A (video) read request.
REQ-006 a_addr  input  23  port A byte address.
REQ-007 a_ack  output  1  port A request accepted; combinational, asserted only in IDLE.
REQ-008 a_valid  output  1  one-cycle pulse; a_data is valid.
REQ-009 a_data  output  32  port A read data.
REQ-010 b_req, b_we  input  1 each  port B (CPU) request; b_we=1 selects write.
REQ-011 b_addr  input  23; b_din  input  16; b_wdm  input  2  port B byte address, write data, write byte mask.
REQ-012 b_ack  output  1; b_done  output  1; b_dout  output  16  port B accept, completion pulse, read data.
REQ-013 mem_rd, mem_wr, mem_refresh  output  1 each  controller command strobes.
REQ-014 mem_addr  output  23; mem_din  output  16; mem_wdm  output  2  controller operands.
REQ-015 mem_dout  input  16; mem_dout32  input  32; mem_data_ready, mem_busy, mem_enabled  input  1 each  controller status.
REQ-016 refresh_overrun  output  1  sticky; set when the owed-refresh count saturates.

Function
REQ-017 The FSM SHALL have states INIT, IDLE, CMD, WAIT_ACK and WAIT_DONE.
REQ-018 INIT: the FSM SHALL move to IDLE on the first cycle with mem_enabled=1 and mem_busy=0.
REQ-019 The refresh timer SHALL run from reset, including during INIT, and tick every REFRESH_CYCLES cycles.
REQ-020 Each tick SHALL increment a 2-bit owed-refresh count, saturating at 3; a tick at count 3 SHALL set refresh_overrun.
REQ-021 IDLE priority (with mem_busy=0): owed>0 → refresh; else a single requester wins; else A and B both requesting → the port not granted last (round-robin, A first after reset).
REQ-022 On a grant, the FSM SHALL register mem_addr/mem_din/mem_wdm from the winning port and assert exactly one strobe for one cycle (the CMD state).
REQ-023 On a grant, the FSM SHALL assert x_ack combinationally in the same cycle.
REQ-024 A requester still asserting x_req on the cycle after its ack SHALL be treated as a new request.
REQ-025 A refresh grant SHALL decrement the owed count.
REQ-026 b_wdm=00 SHALL be driven as 11; port A SHALL always issue mem_rd with mem_wdm=11.
REQ-027 mem_addr, mem_din and mem_wdm SHALL be held stable from CMD until return to IDLE.
REQ-028 CMD → WAIT_ACK unconditionally.
REQ-029 WAIT_ACK → WAIT_DONE when mem_busy=1.
REQ-030 WAIT_DONE → IDLE when mem_busy=0.
REQ-031 On mem_data_ready=1, mem_dout32 SHALL be captured into a_data for port A reads, and mem_dout into b_dout for port B reads.
REQ-032 On the WAIT_DONE→IDLE edge, the owner's a_valid or b_done SHALL pulse for one cycle, registered; a refresh completion SHALL produce no pulse.
REQ-033 At most one command SHALL be outstanding; requests arriving outside IDLE wait, with no ack.
REQ-034 A tick arriving during any state SHALL only increment the owed count; it SHALL never abort a transfer.
REQ-035 With mem_busy=0 in IDLE and a request present, the grant latency SHALL be 0 cycles (ack and the strobe register update at the same edge).

Reset
REQ-036 While resetn=0: state=INIT, all strobes=0, a_ack/b_ack/a_valid/b_done=0, a_data=0, b_dout=0, mem_addr=0, mem_din=0, mem_wdm=11, owed count=0, timer=0, refresh_overrun=0, round-robin pointer=A.
REQ-037 Reset asserted mid-transfer SHALL discard the transfer with no completion pulse.
REQ-038 After reset, the block SHALL re-enter INIT and wait for the controller per REQ-018.

Structure
REQ-039 Package sdram_sched_pkg SHALL hold the state enum, the owner enum {OWN_REF, OWN_A, OWN_B} and the REFRESH_CYCLES calculation.
REQ-040 Sub-module sdram_refresh_timer SHALL hold the interval counter plus the owed count and overrun logic, with a tick/consume interface.

Verification
REQ-041 Bench with a controller model (busy 1 cycle after strobe, data_ready 3 cycles later, busy low 1 cycle after that): a_req, a_addr=0x000104, model returns 0xDEADBEEF → one mem_rd, mem_addr=0x000104, a_valid with a_data=0xDEADBEEF.
REQ-042 b_req/b_we=1, b_addr=0x000003, b_din=0x5AA5, b_wdm=00 → mem_wr with mem_wdm=11, mem_din=0x5AA5, b_done once, no a_valid.
REQ-043 a_req and b_req held continuously → grants alternate A,B,A,B; none missed over 20 grants.
REQ-044 mem_busy forced high for 4000 cycles at FREQ=54 MHz → refresh_overrun=1, owed=3; on release, three consecutive mem_refresh are issued before any client grant.
REQ-045 resetn pulsed low during WAIT_DONE of a port B read → no b_done; INIT re-entered; no strobe until mem_enabled=1 and mem_busy=0.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM request scheduler.
//   state_t  : scheduler FSM states
//   owner_t  : which agent owns the command currently in flight
//   calc_refresh_cycles : clock cycles between refresh ticks
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_REF,
        OWN_A,
        OWN_B
    } owner_t;

    function automatic int unsigned calc_refresh_cycles(input int unsigned freq,
                                                        input int unsigned refresh_us);
        return freq / 1_000_000 * refresh_us;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with a saturating count of owed refreshes.
//   clk, resetn : clock, asynchronous active-low reset
//   consume     : one owed refresh has been granted this cycle
//   owed        : refreshes owed to the controller (0..3)
//   overrun     : sticky, a tick arrived while owed was already 3
module sdram_refresh_timer #(
    parameter int unsigned CYCLES = 810
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       consume,
    output logic [1:0] owed,
    output logic       overrun
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;
    logic          tick;

    assign tick = (count == CW'(CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A tick and a consume in the same cycle cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owed    <= '0;
            overrun <= 1'b0;
        end else begin
            case ({tick, consume})
                2'b10: begin
                    if (owed == 2'd3) begin
                        overrun <= 1'b1;
                    end else begin
                        owed <= owed + 2'd1;
                    end
                end
                2'b01: begin
                    if (owed != 2'd0) begin
                        owed <= owed - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sdram_scheduler.sv
// Two-port scheduler in front of an SDRAM controller: interleaves periodic
// refreshes, video reads (port A) and CPU reads/writes (port B), one command
// outstanding at a time.
//   clk, resetn                 : clock, asynchronous active-low reset
//   a_req/a_addr/a_ack          : port A read request, address, accept
//   a_valid/a_data              : port A completion pulse and 32-bit read data
//   b_req/b_we/b_addr/b_din/b_wdm : port B request, write select, operands
//   b_ack/b_done/b_dout         : port B accept, completion pulse, read data
//   mem_rd/mem_wr/mem_refresh   : controller command strobes
//   mem_addr/mem_din/mem_wdm    : controller operands, stable during a command
//   mem_dout/mem_dout32/mem_data_ready/mem_busy/mem_enabled : controller status
//   refresh_overrun             : sticky, owed-refresh count saturated
module sdram_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int unsigned FREQ       = 54_000_000,
    parameter int unsigned REFRESH_US = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_req,
    input  logic [22:0] a_addr,
    output logic        a_ack,
    output logic        a_valid,
    output logic [31:0] a_data,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [22:0] b_addr,
    input  logic [15:0] b_din,
    input  logic [1:0]  b_wdm,
    output logic        b_ack,
    output logic        b_done,
    output logic [15:0] b_dout,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_refresh,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_wdm,
    input  logic [15:0] mem_dout,
    input  logic [31:0] mem_dout32,
    input  logic        mem_data_ready,
    input  logic        mem_busy,
    input  logic        mem_enabled,
    output logic        refresh_overrun
);

    localparam int unsigned REFRESH_CYCLES = calc_refresh_cycles(FREQ, REFRESH_US);

    state_t     state, state_next;
    owner_t     owner;
    logic       cmd_we;
    logic       prefer_b;
    logic [1:0] owed;
    logic       grant_ref, grant_a, grant_b;

    sdram_refresh_timer #(
        .CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .resetn  (resetn),
        .consume (grant_ref),
        .owed    (owed),
        .overrun (refresh_overrun)
    );

    // Refresh first, then a lone requester, then round-robin on contention.
    always_comb begin
        grant_ref = 1'b0;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (state == ST_IDLE && !mem_busy) begin
            if (owed != 2'd0) begin
                grant_ref = 1'b1;
            end else if (a_req && (!b_req || !prefer_b)) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:      if (mem_enabled && !mem_busy) state_next = ST_IDLE;
            ST_IDLE:      if (grant_ref || grant_a || grant_b) state_next = ST_CMD;
            ST_CMD:       state_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (mem_busy) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!mem_busy) state_next = ST_IDLE;
            default:      state_next = ST_INIT;
        endcase
    end

    always_comb begin
        a_ack       = grant_a;
        b_ack       = grant_b;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_refresh = 1'b0;
        if (state == ST_CMD) begin
            case (owner)
                OWN_REF: mem_refresh = 1'b1;
                OWN_A:   mem_rd      = 1'b1;
                OWN_B: begin
                    if (cmd_we) begin
                        mem_wr = 1'b1;
                    end else begin
                        mem_rd = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands, ownership, read-data capture and completion pulses.
    // Refresh grants leave the operand registers untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner    <= OWN_REF;
            cmd_we   <= 1'b0;
            prefer_b <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wdm  <= '1;
            a_data   <= '0;
            b_dout   <= '0;
            a_valid  <= 1'b0;
            b_done   <= 1'b0;
        end else begin
            a_valid <= (state == ST_WAIT_DONE) && !mem_busy && (owner == OWN_A);
            b_done  <= (state == ST_WAIT_DONE) && !mem_busy && (owner == OWN_B);
            if (grant_ref) begin
                owner <= OWN_REF;
            end
            if (grant_a) begin
                owner    <= OWN_A;
                cmd_we   <= 1'b0;
                mem_addr <= a_addr;
                mem_wdm  <= '1;
                prefer_b <= 1'b1;
            end
            if (grant_b) begin
                owner    <= OWN_B;
                cmd_we   <= b_we;
                mem_addr <= b_addr;
                mem_din  <= b_din;
                mem_wdm  <= (b_wdm == 2'b00) ? 2'b11 : b_wdm;
                prefer_b <= 1'b0;
            end
            if (mem_data_ready && state != ST_IDLE && state != ST_INIT) begin
                if (owner == OWN_A) begin
                    a_data <= mem_dout32;
                end
                if (owner == OWN_B && !cmd_we) begin
                    b_dout <= mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_scheduler.sv
module tb_sdram_scheduler;

    localparam int unsigned REF_CYC = 54_000_000 / 1_000_000 * 15;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_ack, a_valid;
    logic [22:0] a_addr;
    logic [31:0] a_data;
    logic        b_req, b_we, b_ack, b_done;
    logic [22:0] b_addr;
    logic [15:0] b_din, b_dout;
    logic [1:0]  b_wdm;
    logic        mem_rd, mem_wr, mem_refresh;
    logic [22:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic [1:0]  mem_wdm;
    logic [31:0] mem_dout32;
    logic        mem_data_ready, mem_busy, mem_enabled;
    logic        refresh_overrun;

    logic        model_busy, force_busy;
    logic [31:0] model_d32;
    logic [15:0] model_d16;
    int          k;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt = 0, wr_cnt = 0, ref_cnt = 0, av_cnt = 0, bd_cnt = 0, multi_cnt = 0;
    int cyc = 0;
    int first_ref_cyc = -1;
    bit model_last_b;

    assign mem_busy = model_busy | force_busy;

    sdram_scheduler #(
        .FREQ       (54_000_000),
        .REFRESH_US (15)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .a_req           (a_req),
        .a_addr          (a_addr),
        .a_ack           (a_ack),
        .a_valid         (a_valid),
        .a_data          (a_data),
        .b_req           (b_req),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_din           (b_din),
        .b_wdm           (b_wdm),
        .b_ack           (b_ack),
        .b_done          (b_done),
        .b_dout          (b_dout),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_refresh     (mem_refresh),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_wdm         (mem_wdm),
        .mem_dout        (mem_dout),
        .mem_dout32      (mem_dout32),
        .mem_data_ready  (mem_data_ready),
        .mem_busy        (mem_busy),
        .mem_enabled     (mem_enabled),
        .refresh_overrun (refresh_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!resetn) cyc = 0;
        else         cyc = cyc + 1;
    end

    // Controller model: busy one cycle after the strobe, data_ready three
    // cycles later, busy low one cycle after that.
    always @(negedge clk) begin
        if (!resetn) begin
            k = 0;
            model_busy = 1'b0;
            mem_data_ready = 1'b0;
        end else if (k == 0) begin
            if (mem_rd || mem_wr || mem_refresh) k = 1;
        end else begin
            k = k + 1;
            if (k == 2) model_busy = 1'b1;
            if (k == 5) begin
                mem_data_ready = 1'b1;
                mem_dout32 = model_d32;
                mem_dout = model_d16;
            end
            if (k == 6) begin
                mem_data_ready = 1'b0;
                model_busy = 1'b0;
                k = 0;
            end
        end
    end

    always @(negedge clk) begin
        rd_cnt  += int'(mem_rd);
        wr_cnt  += int'(mem_wr);
        ref_cnt += int'(mem_refresh);
        av_cnt  += int'(a_valid);
        bd_cnt  += int'(b_done);
        if (int'(mem_rd) + int'(mem_wr) + int'(mem_refresh) > 1) multi_cnt++;
        if (first_ref_cyc < 0 && mem_refresh) first_ref_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_wdm(input logic [1:0] w);
        return (w == 2'b00) ? 2'b11 : w;
    endfunction

    task automatic wait_ack(input bit is_b, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (is_b ? b_ack : a_ack) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_txn(input bit is_b, input bit we, input logic [22:0] addr,
                          input logic [15:0] din, input logic [1:0] wdm,
                          input logic [31:0] d32, input logic [15:0] d16);
        int rd0, wr0, av0, bd0;
        bit seen;
        rd0 = rd_cnt; wr0 = wr_cnt; av0 = av_cnt; bd0 = bd_cnt;
        model_d32 = d32;
        model_d16 = d16;
        @(negedge clk);
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_din = din; b_wdm = wdm;
        end else begin
            a_req = 1'b1; a_addr = addr;
        end
        wait_ack(is_b, 3000, seen);
        check("ack_seen", 32'(seen), 1);
        if (!seen) begin
            a_req = 1'b0;
            b_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        check("strobe", 32'({mem_rd, mem_wr, mem_refresh}), (is_b && we) ? 3'b010 : 3'b100);
        check("mem_addr", 32'(mem_addr), 32'(addr));
        check("mem_wdm", 32'(mem_wdm), is_b ? 32'(exp_wdm(wdm)) : 32'd3);
        if (is_b && we) check("mem_din", 32'(mem_din), 32'(din));
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_b ? b_done : a_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 1);
        check("hold_addr", 32'(mem_addr), 32'(addr));
        if (!is_b)    check("a_data", a_data, d32);
        else if (!we) check("b_dout", 32'(b_dout), 32'(d16));
        repeat (3) @(negedge clk);
        check("n_rd", rd_cnt - rd0, (is_b && we) ? 0 : 1);
        check("n_wr", wr_cnt - wr0, (is_b && we) ? 1 : 0);
        check("n_aval", av_cnt - av0, is_b ? 0 : 1);
        check("n_bdone", bd_cnt - bd0, is_b ? 1 : 0);
        model_last_b = is_b;
    endtask

    task automatic rr_test();
        int n, bad, av0, bd0;
        bit exp_b;
        av0 = av_cnt; bd0 = bd_cnt;
        model_d32 = 32'h0BAD_F00D;
        model_d16 = 16'hC0DE;
        @(negedge clk);
        a_req = 1'b1; a_addr = 23'h000200;
        b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000300;
        exp_b = !model_last_b;
        n = 0;
        bad = 0;
        for (int i = 0; i < 3000 && n < 20; i++) begin
            #1;
            if (a_ack && b_ack) begin
                bad++;
            end else if (a_ack || b_ack) begin
                if (b_ack != exp_b) bad++;
                exp_b = !exp_b;
                n++;
            end
            @(negedge clk);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        model_last_b = !exp_b;
        repeat (20) @(negedge clk);
        check("rr_grants", n, 20);
        check("rr_order", bad, 0);
        check("rr_aval", av_cnt - av0, 10);
        check("rr_bdone", bd_cnt - bd0, 10);
    endtask

    task automatic overrun_test();
        int r0;
        bit seen;
        check("ovr_pre", 32'(refresh_overrun), 0);
        @(negedge clk);
        force_busy = 1'b1;
        repeat (4000) @(negedge clk);
        // Release well clear of the next tick so exactly three are owed.
        while ((cyc % REF_CYC) != 100) @(negedge clk);
        check("ovr_set", 32'(refresh_overrun), 1);
        a_req = 1'b1; a_addr = 23'h000010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000020;
        r0 = ref_cnt;
        force_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (a_ack || b_ack) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ovr_client", 32'(seen), 1);
        check("ovr_refs_first", ref_cnt - r0, 3);
        check("ovr_rr_port", 32'(b_ack), 32'(!model_last_b));
        model_last_b = !model_last_b;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (15) @(negedge clk);
        check("ovr_sticky", 32'(refresh_overrun), 1);
        check("ovr_no_more_refs", ref_cnt - r0, 3);
    endtask

    task automatic reset_test();
        bit seen;
        int bd0, s0, acks;
        model_d16 = 16'h1234;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000456; b_wdm = 2'b00;
        wait_ack(1'b1, 3000, seen);
        check("rst_b_ack", 32'(seen), 1);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_in_wait_done", 32'(mem_busy), 1);
        bd0 = bd_cnt;
        resetn = 1'b0;
        mem_enabled = 1'b0;
        #1;
        check("rst_strobes", 32'({mem_rd, mem_wr, mem_refresh}), 0);
        check("rst_pulses", 32'({a_valid, b_done, a_ack, b_ack}), 0);
        check("rst_overrun", 32'(refresh_overrun), 0);
        check("rst_operands", {mem_addr, mem_wdm}, {23'd0, 2'b11});
        check("rst_b_dout", 32'(b_dout), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        first_ref_cyc = -1;
        s0 = rd_cnt + wr_cnt + ref_cnt;
        a_req = 1'b1; a_addr = 23'h000777;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (a_ack) acks++;
        end
        mem_enabled = 1'b1;
        force_busy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (a_ack) acks++;
        end
        check("init_no_ack", acks, 0);
        check("init_no_strobe", rd_cnt + wr_cnt + ref_cnt - s0, 0);
        check("rst_no_bdone", bd_cnt - bd0, 0);
        a_req = 1'b0;
        force_busy = 1'b0;
        model_last_b = 1'b1;
        do_txn(1'b0, 1'b0, 23'h000777, 16'h0, 2'b00, 32'h600D_CAFE, 16'h0);
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (first_ref_cyc >= 0) break;
        end
        check("first_refresh_time",
              32'(first_ref_cyc >= int'(REF_CYC) && first_ref_cyc <= int'(REF_CYC) + 2), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        a_req = 1'b1; a_addr = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_din = '0; b_wdm = '0;
        mem_enabled = 1'b1;
        force_busy = 1'b0;
        model_busy = 1'b0;
        mem_data_ready = 1'b0;
        mem_dout = '0;
        mem_dout32 = '0;
        model_d32 = '0;
        model_d16 = '0;
        model_last_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("por_acks", 32'({a_ack, b_ack}), 0);
        check("por_strobes", 32'({mem_rd, mem_wr, mem_refresh}), 0);
        check("por_pulses", 32'({a_valid, b_done}), 0);
        check("por_a_data", a_data, 0);
        check("por_b_dout", 32'(b_dout), 0);
        check("por_operands", {mem_addr, mem_din, mem_wdm}, {23'd0, 16'd0, 2'b11});
        check("por_overrun", 32'(refresh_overrun), 0);
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        do_txn(1'b0, 1'b0, 23'h000104, 16'h0, 2'b00, 32'hDEADBEEF, 16'h0);
        do_txn(1'b1, 1'b1, 23'h000003, 16'h5AA5, 2'b00, 32'h0, 16'h0);

        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom), 1'($urandom), 23'($urandom), 16'($urandom),
                   2'($urandom_range(0, 3)), $urandom, 16'($urandom));
        end

        rr_test();
        overrun_test();
        reset_test();

        check("one_strobe_at_a_time", multi_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
